// File: rtl/inst_fetch_pkg.sv
// rtl/inst_fetch_pkg.sv - shared word/address widths and instruction field constants
package inst_fetch_pkg;

    localparam int WORD_WIDTH     = 32;
    localparam int MEM_ADDR_WIDTH = 32;

    // Primary opcodes (inst[31:26]) and R-type funct codes (inst[5:0])
    localparam logic [5:0] OP_RTYPE  = 6'h00;
    localparam logic [5:0] OP_J      = 6'h02;
    localparam logic [5:0] OP_JAL    = 6'h03;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] FUNCT_JR  = 6'h08;
    localparam logic [5:0] FUNCT_ADD = 6'h20;

    localparam logic [WORD_WIDTH-1:0] NOP_WORD = '0;

    // Branch displacement: sign-extended word offset converted to a byte offset
    function automatic logic [MEM_ADDR_WIDTH-1:0] branch_offset(input logic [15:0] imm);
        return {{(MEM_ADDR_WIDTH-18){imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/inst_fetch_next_pc_mux.sv
// rtl/inst_fetch_next_pc_mux.sv - next-PC target select and jr alignment check
module inst_fetch_next_pc_mux
    import inst_fetch_pkg::*;
#(
    parameter int ADDR_WIDTH = MEM_ADDR_WIDTH
) (
    input  logic [ADDR_WIDTH-1:0] pc_plus4,
    input  logic [25:0]           inst_index,
    input  logic                  pc_src,
    input  logic                  jump,
    input  logic                  jr,
    input  logic [ADDR_WIDTH-1:0] rs_data,
    output logic [ADDR_WIDTH-1:0] next_pc,
    output logic                  jr_misaligned
);

    // Priority jr > jump > taken branch > sequential; jr target is forced word aligned
    always_comb begin
        next_pc = pc_plus4;
        if (jr) begin
            next_pc = {rs_data[ADDR_WIDTH-1:2], 2'b00};
        end else if (jump) begin
            next_pc = {pc_plus4[ADDR_WIDTH-1:ADDR_WIDTH-4], inst_index, 2'b00};
        end else if (pc_src) begin
            next_pc = pc_plus4 + branch_offset(inst_index[15:0]);
        end
    end

    // Misalignment only matters when jr is actually selecting the target
    always_comb begin
        jr_misaligned = jr && (rs_data[1:0] != 2'b00);
    end

endmodule

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - PC holder and req/ack instruction fetch FSM
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          ADDR_WIDTH = MEM_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  nrst,
    output logic                  imem_req,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic                  imem_ack,
    input  logic [WORD_WIDTH-1:0] imem_rdata,
    output logic [WORD_WIDTH-1:0] inst,
    output logic                  inst_valid,
    input  logic                  stall,
    input  logic                  pc_src,
    input  logic                  jump,
    input  logic                  jr,
    input  logic [ADDR_WIDTH-1:0] rs_data,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic [ADDR_WIDTH-1:0] pc_plus4,
    output logic                  fetch_err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_WAIT  = 2'd2,
        S_EXEC  = 2'd3
    } state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   pc_q;
    logic [WORD_WIDTH-1:0]   inst_q;
    logic                    req_q;
    logic                    valid_q;
    logic                    fetch_err_q;
    logic [ADDR_WIDTH-1:0]   next_pc;
    logic                    jr_misaligned;

    // Incrementer is free-running so the jal link value is available in every state
    always_comb begin
        pc_plus4 = pc_q + ADDR_WIDTH'(4);
    end

    inst_fetch_next_pc_mux #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_next_pc_mux (
        .pc_plus4      (pc_plus4),
        .inst_index    (inst_q[25:0]),
        .pc_src        (pc_src),
        .jump          (jump),
        .jr            (jr),
        .rs_data       (rs_data),
        .next_pc       (next_pc),
        .jr_misaligned (jr_misaligned)
    );

    // Fetch FSM; req/valid are registered alongside state so reset clears them at once
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state       <= S_IDLE;
            pc_q        <= RESET_PC[ADDR_WIDTH-1:0];
            inst_q      <= NOP_WORD;
            req_q       <= 1'b0;
            valid_q     <= 1'b0;
            fetch_err_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    state <= S_FETCH;
                    req_q <= 1'b1;
                end
                S_FETCH, S_WAIT: begin
                    if (imem_ack) begin
                        inst_q  <= imem_rdata;
                        state   <= S_EXEC;
                        req_q   <= 1'b0;
                        valid_q <= 1'b1;
                    end else begin
                        state <= S_WAIT;
                    end
                end
                S_EXEC: begin
                    // Control inputs are only honoured on the cycle execute retires
                    if (!stall) begin
                        pc_q    <= next_pc;
                        state   <= S_FETCH;
                        req_q   <= 1'b1;
                        valid_q <= 1'b0;
                        if (jr_misaligned) begin
                            fetch_err_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    req_q   <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Decoder sees a NOP whenever no instruction is being executed
    always_comb begin
        imem_req   = req_q;
        imem_addr  = pc_q;
        pc         = pc_q;
        inst_valid = valid_q;
        inst       = valid_q ? inst_q : NOP_WORD;
        fetch_err  = fetch_err_q;
    end

endmodule

// File: tb/tb_inst_fetch.sv
// tb/tb_inst_fetch.sv - directed self-checking bench for inst_fetch
module tb_inst_fetch;
    import inst_fetch_pkg::*;

    logic        clk;
    logic        nrst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] inst;
    logic        inst_valid;
    logic        stall;
    logic        pc_src;
    logic        jump;
    logic        jr;
    logic [31:0] rs_data;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        fetch_err;

    int checks   = 0;
    int failures = 0;

    logic [31:0] add_w;
    logic [31:0] beq_w;
    logic [31:0] jal_w;
    logic [31:0] jr_w;

    inst_fetch #(
        .RESET_PC   (32'h0000_0000),
        .ADDR_WIDTH (32)
    ) dut (
        .clk        (clk),
        .nrst       (nrst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .inst       (inst),
        .inst_valid (inst_valid),
        .stall      (stall),
        .pc_src     (pc_src),
        .jump       (jump),
        .jr         (jr),
        .rs_data    (rs_data),
        .pc         (pc),
        .pc_plus4   (pc_plus4),
        .fetch_err  (fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Entered at a falling edge with the DUT in FETCH; acks after 'waits' extra cycles
    task automatic do_fetch(input logic [31:0] addr, input logic [31:0] word, input int waits);
        for (int i = 0; i <= waits; i++) begin
            chk("req_during_fetch", {31'd0, imem_req}, 32'd1);
            chk("addr_during_fetch", imem_addr, addr);
            chk("valid_during_fetch", {31'd0, inst_valid}, 32'd0);
            chk("inst_nop_during_fetch", inst, 32'd0);
            imem_ack   = (i == waits);
            imem_rdata = (i == waits) ? word : 32'hDEAD_BEEF;
            @(negedge clk);
        end
        imem_ack   = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        chk("valid_in_exec", {31'd0, inst_valid}, 32'd1);
        chk("inst_in_exec", inst, word);
        chk("pc_in_exec", pc, addr);
        chk("req_low_in_exec", {31'd0, imem_req}, 32'd0);
        chk("pc_plus4_in_exec", pc_plus4, addr + 32'd4);
    endtask

    // One non-stalled execute cycle with the given controller outputs
    task automatic do_exec(input logic s, input logic j, input logic r, input logic [31:0] rs);
        stall   = 1'b0;
        pc_src  = s;
        jump    = j;
        jr      = r;
        rs_data = rs;
        @(negedge clk);
        pc_src  = 1'b0;
        jump    = 1'b0;
        jr      = 1'b0;
        rs_data = 32'd0;
    endtask

    initial begin
        add_w = {OP_RTYPE, 5'd1, 5'd2, 5'd3, 5'd0, FUNCT_ADD};
        beq_w = {OP_BEQ, 5'd1, 5'd2, 16'hFFFE};
        jal_w = {OP_JAL, 26'h000_0040};
        jr_w  = {OP_RTYPE, 5'd31, 15'd0, FUNCT_JR};

        nrst       = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = 32'h1234_5678;
        stall      = 1'b0;
        pc_src     = 1'b0;
        jump       = 1'b0;
        jr         = 1'b0;
        rs_data    = 32'd0;

        // Reset state with a stray ack present
        repeat (3) @(negedge clk);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_valid", {31'd0, inst_valid}, 32'd0);
        chk("rst_inst", inst, 32'd0);
        chk("rst_pc", pc, 32'd0);
        chk("rst_pc_plus4", pc_plus4, 32'd4);
        chk("rst_fetch_err", {31'd0, fetch_err}, 32'd0);
        imem_ack = 1'b0;
        nrst     = 1'b1;
        @(negedge clk);

        // Zero-wait fetch at 0x0, then 3-cycle-late ack at 0x4
        do_fetch(32'h0, add_w, 0);
        do_exec(1'b0, 1'b0, 1'b0, 32'd0);
        do_fetch(32'h4, add_w, 3);
        do_exec(1'b0, 1'b0, 1'b0, 32'd0);

        // Taken branch back to 0x4, then the same branch not taken
        do_fetch(32'h8, beq_w, 0);
        do_exec(1'b1, 1'b0, 1'b0, 32'd0);
        do_fetch(32'h4, add_w, 0);
        do_exec(1'b0, 1'b0, 1'b0, 32'd0);
        do_fetch(32'h8, beq_w, 0);
        do_exec(1'b0, 1'b0, 1'b0, 32'd0);
        do_fetch(32'hC, add_w, 0);
        do_exec(1'b0, 1'b0, 1'b0, 32'd0);

        // jal to 0x100, then jr to misaligned 0x22 with all selects high
        do_fetch(32'h10, jal_w, 0);
        chk("jal_link", pc_plus4, 32'h14);
        do_exec(1'b0, 1'b1, 1'b0, 32'd0);
        do_fetch(32'h100, jr_w, 0);
        chk("err_before_jr", {31'd0, fetch_err}, 32'd0);
        do_exec(1'b1, 1'b1, 1'b1, 32'h22);
        chk("err_after_jr", {31'd0, fetch_err}, 32'd1);

        // Stall for five cycles with a jump request that must be ignored
        do_fetch(32'h20, add_w, 0);
        stall = 1'b1;
        jump  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_pc", pc, 32'h20);
            chk("stall_inst", inst, add_w);
            chk("stall_valid", {31'd0, inst_valid}, 32'd1);
            chk("stall_req", {31'd0, imem_req}, 32'd0);
        end
        jump = 1'b0;
        do_exec(1'b0, 1'b0, 1'b0, 32'd0);
        chk("err_sticky", {31'd0, fetch_err}, 32'd1);

        // Reset asserted mid-wait: request drops immediately
        chk("pre_wait_addr", imem_addr, 32'h24);
        @(negedge clk);
        chk("wait_req", {31'd0, imem_req}, 32'd1);
        chk("wait_addr", imem_addr, 32'h24);
        #2;
        nrst     = 1'b0;
        imem_ack = 1'b1;
        #1;
        chk("async_rst_req", {31'd0, imem_req}, 32'd0);
        chk("async_rst_pc", pc, 32'd0);
        chk("async_rst_err", {31'd0, fetch_err}, 32'd0);
        @(negedge clk);
        chk("rst_ack_ignored_req", {31'd0, imem_req}, 32'd0);
        nrst = 1'b1;
        #1;
        chk("idle_req", {31'd0, imem_req}, 32'd0);
        @(negedge clk);
        imem_ack = 1'b0;
        chk("idle_ack_ignored_valid", {31'd0, inst_valid}, 32'd0);
        do_fetch(32'h0, add_w, 1);

        // Aligned jr to the top word, then sequential wrap to zero
        do_exec(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
        chk("aligned_jr_no_err", {31'd0, fetch_err}, 32'd0);
        do_fetch(32'hFFFF_FFFC, add_w, 0);
        chk("wrap_pc_plus4", pc_plus4, 32'h0);
        do_exec(1'b0, 1'b0, 1'b0, 32'd0);
        do_fetch(32'h0, add_w, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
